// File: rtl/redmule_x_ring_buffer_pkg.sv
// Shared types and defaults for the RedMulE X-operand ring buffer.
// Carries a minimal FP-format enum so the buffer elaborates without the full FPU package.
package redmule_x_ring_buffer_pkg;

  typedef enum logic [2:0] {
    FP32,
    FP64,
    FP16,
    FP8,
    FP16ALT,
    FP8ALT
  } fp_format_e;

  function automatic int fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:          return 32;
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      FP8, FP8ALT:   return 8;
      default:       return 16;
    endcase
  endfunction

  localparam int ARRAY_HEIGHT = 4;
  localparam int ARRAY_WIDTH  = 12;
  localparam int X_RING_DEPTH = 4;

  // Wide enough for any realistic array width; narrower port values are zero-extended.
  localparam int X_RING_CFG_W = 8;

  typedef struct packed {
    logic [X_RING_CFG_W-1:0] rows_lim;
    logic [X_RING_CFG_W-1:0] cols_lim;
    logic [X_RING_CFG_W-1:0] beats_lim;
  } x_ring_cfg_t;

endpackage

// File: rtl/redmule_x_ring_buffer_ctrl.sv
// Pointer, occupancy and beat bookkeeping for the X ring buffer.
// Tile limits are taken from the ports on the first beat and frozen until commit.
module redmule_x_ring_ctrl
  import redmule_x_ring_buffer_pkg::*;
#(
  parameter int Height = ARRAY_HEIGHT,
  parameter int Width  = ARRAY_WIDTH,
  parameter int Depth  = X_RING_DEPTH,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = PtrW + 1,
  localparam int RowsW = $clog2(Width) + 1,
  localparam int ColsW = $clog2(Height) + 1,
  localparam int BeatW = $clog2(Width / Height + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [RowsW-1:0] rows_lftovr,
  input  logic [ColsW-1:0] cols_lftovr,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  level,
  output logic             wr_en,
  output logic             first_beat,
  output logic             commit,
  output logic [PtrW-1:0]  wr_slot,
  output logic [PtrW-1:0]  rd_slot,
  output logic [BeatW-1:0] wr_beat,
  output x_ring_cfg_t      cfg
);

  logic [PtrW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0]  count_reg, count_next;
  logic [BeatW-1:0] beat_cnt_reg, beat_cnt_next;
  x_ring_cfg_t      cfg_reg, cfg_next, cfg_new;
  logic             accept, pop, last_beat;
  int               rows_sat, cols_sat;

  // Saturate the leftover counts: zero or out-of-range means a full dimension.
  always_comb begin
    rows_sat = int'(rows_lftovr);
    if (rows_sat == 0 || rows_sat > Width) rows_sat = Width;
    cols_sat = int'(cols_lftovr);
    if (cols_sat == 0 || cols_sat > Height) cols_sat = Height;
    cfg_new.rows_lim  = X_RING_CFG_W'(rows_sat);
    cfg_new.cols_lim  = X_RING_CFG_W'(cols_sat);
    cfg_new.beats_lim = X_RING_CFG_W'((rows_sat + Height - 1) / Height);
  end

  assign first_beat = (beat_cnt_reg == '0);
  assign cfg        = first_beat ? cfg_new : cfg_reg;
  assign in_ready   = (count_reg < CntW'(Depth));
  assign out_valid  = (count_reg != '0);
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign last_beat  = (X_RING_CFG_W'(beat_cnt_reg) == cfg.beats_lim - X_RING_CFG_W'(1));
  assign commit     = accept && last_beat;

  assign wr_en   = accept;
  assign wr_slot = wr_ptr_reg;
  assign rd_slot = rd_ptr_reg;
  assign wr_beat = beat_cnt_reg;
  assign full    = (count_reg == CntW'(Depth));
  assign empty   = (count_reg == '0) && first_beat;
  assign level   = count_reg;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    beat_cnt_next = beat_cnt_reg;
    cfg_next      = cfg_reg;
    if (accept) begin
      if (first_beat) cfg_next = cfg_new;
      if (last_beat) begin
        wr_ptr_next   = wr_ptr_reg + PtrW'(1);
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + BeatW'(1);
      end
    end
    if (pop) rd_ptr_next = rd_ptr_reg + PtrW'(1);
    if (commit && !pop) begin
      count_next = count_reg + CntW'(1);
    end else if (!commit && pop) begin
      count_next = count_reg - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_cnt_reg <= '0;
      cfg_reg      <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      beat_cnt_reg <= beat_cnt_next;
      cfg_reg      <= cfg_next;
    end
  end

endmodule

// File: rtl/redmule_x_ring_buffer.sv
// D-slot circular store of W x H X-tiles between the streamer and the systolic array.
// Each slot is filled one H x H block per beat with out-of-range rows/columns forced to zero.
module redmule_x_ring_buffer
  import redmule_x_ring_buffer_pkg::*;
#(
  parameter int         DW       = 288,
  parameter fp_format_e FpFormat = FP16,
  parameter int         Height   = ARRAY_HEIGHT,
  parameter int         Width    = ARRAY_WIDTH,
  parameter int         Depth    = X_RING_DEPTH,
  localparam int        BITW     = fp_width(FpFormat),
  localparam int        PtrW     = $clog2(Depth),
  localparam int        CntW     = PtrW + 1,
  localparam int        RowsW    = $clog2(Width) + 1,
  localparam int        ColsW    = $clog2(Height) + 1,
  localparam int        BeatW    = $clog2(Width / Height + 1),
  localparam int        RowW     = Height * BITW,
  localparam int        BlkW     = Height * RowW,
  localparam int        TileW    = Width * RowW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [RowsW-1:0] rows_lftovr_i,
  input  logic [ColsW-1:0] cols_lftovr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    x_buffer_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TileW-1:0] x_buffer_o,
  output logic [Height-1:0] col_mask_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  level_o
);

  logic              wr_en, first_beat, commit;
  logic [PtrW-1:0]   wr_slot, rd_slot;
  logic [BeatW-1:0]  wr_beat;
  x_ring_cfg_t       cfg;
  logic [BlkW-1:0]   beat_padded;
  logic [Height-1:0] mask_new;

  logic [Depth-1:0][TileW-1:0]  slot_data;
  logic [Depth-1:0][Height-1:0] slot_mask;

  redmule_x_ring_ctrl #(
    .Height (Height),
    .Width  (Width),
    .Depth  (Depth)
  ) i_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .rows_lftovr (rows_lftovr_i),
    .cols_lftovr (cols_lftovr_i),
    .in_valid    (in_valid_i),
    .out_ready   (out_ready_i),
    .in_ready    (in_ready_o),
    .out_valid   (out_valid_o),
    .full        (full_o),
    .empty       (empty_o),
    .level       (level_o),
    .wr_en       (wr_en),
    .first_beat  (first_beat),
    .commit      (commit),
    .wr_slot     (wr_slot),
    .rd_slot     (rd_slot),
    .wr_beat     (wr_beat),
    .cfg         (cfg)
  );

  // Padding mux: rows are absolute within the tile, so the beat index selects the row window.
  for (genvar gi = 0; gi < Height; gi++) begin : g_pad_row
    for (genvar gj = 0; gj < Height; gj++) begin : g_pad_col
      assign beat_padded[(gi*Height+gj)*BITW +: BITW] =
        ((int'(wr_beat) * Height + gi) < int'(cfg.rows_lim) && gj < int'(cfg.cols_lim))
          ? x_buffer_i[(gi*Height+gj)*BITW +: BITW] : '0;
    end
  end

  for (genvar gi = 0; gi < Height; gi++) begin : g_mask
    assign mask_new[gi] = (gi < int'(cfg.cols_lim));
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
    logic [TileW-1:0]  data_reg;
    logic [Height-1:0] mask_reg;
    logic              sel;

    assign sel = (wr_slot == PtrW'(gi));

    // The first beat also wipes the rest of the slot so a short tile never exposes stale rows.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        data_reg <= '0;
        mask_reg <= '0;
      end else begin
        if (wr_en && sel) begin
          for (int w = 0; w < Width; w++) begin
            if (w / Height == int'(wr_beat)) begin
              data_reg[w*RowW +: RowW] <= beat_padded[(w % Height)*RowW +: RowW];
            end else if (first_beat) begin
              data_reg[w*RowW +: RowW] <= '0;
            end
          end
        end
        if (commit && sel) mask_reg <= mask_new;
      end
    end

    assign slot_data[gi] = data_reg;
    assign slot_mask[gi] = mask_reg;
  end

  assign x_buffer_o = slot_data[rd_slot];
  assign col_mask_o = slot_mask[rd_slot];

  logic unused_cfg;
  assign unused_cfg = ^cfg.beats_lim;

  if (DW > BlkW) begin : g_unused_beat
    logic unused_beat_bits;
    assign unused_beat_bits = ^x_buffer_i[DW-1:BlkW];
  end

endmodule

// File: tb/tb_redmule_x_ring_buffer.sv
// Directed bench for the X ring buffer: stimulus pushes expected tiles into a scoreboard,
// an independent monitor pops and compares whenever the array side consumes a tile.
module tb_redmule_x_ring_buffer;
  import redmule_x_ring_buffer_pkg::*;

  localparam int H     = 4;
  localparam int W     = 12;
  localparam int D     = 4;
  localparam int BITW  = 16;
  localparam int DW    = 288;
  localparam int TILEW = W * H * BITW;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic [4:0]       rows_lftovr;
  logic [2:0]       cols_lftovr;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    x_in;
  logic             out_valid;
  logic             out_ready;
  logic [TILEW-1:0] x_out;
  logic [H-1:0]     col_mask;
  logic             full;
  logic             empty;
  logic [2:0]       level;

  int n_checks;
  int n_fail;
  int n_tiles;
  logic [TILEW-1:0] exp_q[$];
  logic [H-1:0]     exp_mask_q[$];

  redmule_x_ring_buffer #(
    .DW       (DW),
    .FpFormat (FP16),
    .Height   (H),
    .Width    (W),
    .Depth    (D)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .rows_lftovr_i (rows_lftovr),
    .cols_lftovr_i (cols_lftovr),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .x_buffer_i    (x_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .x_buffer_o    (x_out),
    .col_mask_o    (col_mask),
    .full_o        (full),
    .empty_o       (empty),
    .level_o       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BITW-1:0] val(input int tag, input int w, input int c);
    return BITW'(tag * 64 + w * H + c);
  endfunction

  function automatic logic [DW-1:0] beat_data(input int tag, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < H; c++)
        d[(r*H+c)*BITW +: BITW] = val(tag, b * H + r, c);
    return d;
  endfunction

  function automatic logic [TILEW-1:0] exp_tile(input int tag, input int rows, input int cols);
    logic [TILEW-1:0] t;
    t = '0;
    for (int w = 0; w < W; w++)
      for (int c = 0; c < H; c++)
        if (w < rows && c < cols) t[(w*H+c)*BITW +: BITW] = val(tag, w, c);
    return t;
  endfunction

  function automatic logic [BITW-1:0] elem(input logic [TILEW-1:0] t, input int w, input int c);
    return t[(w*H+c)*BITW +: BITW];
  endfunction

  task automatic check(input string name, input logic [TILEW-1:0] act, input logic [TILEW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int rl, input int cl);
    int  waited;
    bit  acc;
    waited = 0;
    acc    = 1'b0;
    x_in        = d;
    rows_lftovr = 5'(rl);
    cols_lftovr = 3'(cl);
    in_valid    = 1'b1;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL beat_accept: got no in_ready within %0d cycles, required acceptance", waited);
    end
  endtask

  task automatic send_tile(input int tag, input int rl, input int cl);
    int rows, cols, beats;
    rows  = (rl == 0 || rl > W) ? W : rl;
    cols  = (cl == 0 || cl > H) ? H : cl;
    beats = (rows + H - 1) / H;
    for (int b = 0; b < beats; b++) send_beat(beat_data(tag, b), rl, cl);
    exp_q.push_back(exp_tile(tag, rows, cols));
    exp_mask_q.push_back(H'((1 << cols) - 1));
    $display("sent tile tag=%0d rows=%0d cols=%0d beats=%0d", tag, rows, cols, beats);
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (level != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    check("drain_level", TILEW'(level), TILEW'(0));
  endtask

  // Monitor: the array side consumes the head tile at the next edge when valid and ready.
  initial begin
    logic [TILEW-1:0] e;
    logic [H-1:0]     m;
    n_tiles = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tile: got tile %0h, required none", x_out);
        end else begin
          e = exp_q.pop_front();
          m = exp_mask_q.pop_front();
          check("tile_data", x_out, e);
          check("tile_mask", TILEW'(col_mask), TILEW'(m));
          $display("popped tile %0d mask=%b", n_tiles, col_mask);
          n_tiles++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  int rl_tab[8] = '{1, 2, 3, 4, 4, 2, 1, 3};
  int cl_tab[8] = '{1, 2, 3, 4, 0, 3, 2, 1};

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    x_in        = '0;
    rows_lftovr = '0;
    cols_lftovr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", TILEW'(in_ready), TILEW'(1));
    check("rst_out_valid", TILEW'(out_valid), TILEW'(0));
    check("rst_empty", TILEW'(empty), TILEW'(1));
    check("rst_full", TILEW'(full), TILEW'(0));
    check("rst_level", TILEW'(level), TILEW'(0));
    check("rst_x_buffer", x_out, TILEW'(0));
    check("rst_col_mask", TILEW'(col_mask), TILEW'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of a tile
    send_beat(beat_data(7, 0), 0, 0);
    check("mid_empty", TILEW'(empty), TILEW'(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_empty", TILEW'(empty), TILEW'(1));
    check("mid_rst_level", TILEW'(level), TILEW'(0));

    // Full tile, element = linear index
    send_tile(0, 0, 0);
    check("full_out_valid", TILEW'(out_valid), TILEW'(1));
    check("full_level", TILEW'(level), TILEW'(1));
    check("full_mask", TILEW'(col_mask), TILEW'(4'b1111));
    check("full_e5_2", TILEW'(elem(x_out, 5, 2)), TILEW'(16'd22));
    check("full_e11_3", TILEW'(elem(x_out, 11, 3)), TILEW'(16'd47));
    drain();
    check("full_empty_after", TILEW'(empty), TILEW'(1));

    // Leftover rows/columns: 5 rows, 3 columns, two beats
    send_tile(1, 5, 3);
    check("lft_level", TILEW'(level), TILEW'(1));
    check("lft_mask", TILEW'(col_mask), TILEW'(4'b0111));
    check("lft_e4_2", TILEW'(elem(x_out, 4, 2)), TILEW'(16'd82));
    check("lft_e4_3", TILEW'(elem(x_out, 4, 3)), TILEW'(16'd0));
    check("lft_e5_0", TILEW'(elem(x_out, 5, 0)), TILEW'(16'd0));
    drain();

    // Fill to full, hold the 13th beat, pop once
    for (int t = 2; t < 6; t++) send_tile(t, 0, 0);
    check("fill_full", TILEW'(full), TILEW'(1));
    check("fill_in_ready", TILEW'(in_ready), TILEW'(0));
    check("fill_level", TILEW'(level), TILEW'(4));
    x_in        = beat_data(6, 0);
    rows_lftovr = '0;
    cols_lftovr = '0;
    in_valid    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("hold_level", TILEW'(level), TILEW'(4));
    out_ready = 1'b1;
    @(negedge clk);
    check("pop_full_in_ready", TILEW'(in_ready), TILEW'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_pop_in_ready", TILEW'(in_ready), TILEW'(1));
    check("after_pop_level", TILEW'(level), TILEW'(3));
    send_tile(6, 0, 0);
    check("refill_level", TILEW'(level), TILEW'(4));
    drain();

    // Streaming: one-beat tiles commit while the previous one pops
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_tile(10 + i, rl_tab[i], cl_tab[i]);
      check("stream_level", TILEW'(level), TILEW'(1));
    end
    send_tile(18, 0, 2);
    send_tile(19, 7, 0);
    drain();

    // Clear together with a commit and a pop
    send_tile(20, 4, 0);
    send_beat(beat_data(21, 0), 8, 0);
    check("pre_clear_level", TILEW'(level), TILEW'(1));
    x_in        = beat_data(21, 1);
    rows_lftovr = 5'd8;
    cols_lftovr = 3'd0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    clear       = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_level", TILEW'(level), TILEW'(0));
    check("clr_empty", TILEW'(empty), TILEW'(1));
    check("clr_out_valid", TILEW'(out_valid), TILEW'(0));
    check("clr_x_buffer", x_out, TILEW'(0));
    check("clr_col_mask", TILEW'(col_mask), TILEW'(0));
    send_tile(22, 0, 0);
    check("clr_restart_level", TILEW'(level), TILEW'(1));
    drain();

    check("scoreboard_left", TILEW'(exp_q.size()), TILEW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
